port_tx_rsp_arb: RTL
====================

// Module: port_tx_rsp_arb
// PURPOSE
// - Packet-atomic 2:1 arbiter directly downstream of the AFU TX store-and-forward FIFO.
// - Merges the AFU TX stream with the port MMIO read-response stream onto one upstream AXI-S TX link.
// - Never interleaves beats of different packets.
// - Gives MMIO responses priority whenever the AFU FIFO reports idle; bounds MMIO starvation.
// - Registers the merged stream through a 2-entry skid buffer for timing.
// PARAMETERS
// DATA_W        512         tdata width
// USER_W        10          tuser_vendor width
// KEEP_W        DATA_W/8    tkeep width
// STARVE_LIMIT  4           consecutive AFU packets allowed while an MMIO response waits (>=1)
// CNT_W         16          width of packet statistics counters
// PORTS
// clk                  in   1       clock
// rst_n                in   1       synchronous, active-low reset
// i_afu_tvalid         in   1       AFU path (TX FIFO output) valid
// o_afu_tready         out  1       AFU path ready
// i_afu_tdata/tkeep/tuser/tlast  in  DATA_W/KEEP_W/USER_W/1  AFU beat
// i_sel_mmio_rsp       in   1       AFU FIFO empty and no AFU packet in flight (registered upstream)
// i_mmio_tvalid        in   1       MMIO response valid
// o_mmio_tready        out  1       MMIO response ready
// i_mmio_tdata/tkeep/tuser/tlast DATA_W/KEEP_W/USER_W/1  MMIO beat
// o_tx_tvalid          out  1       merged output valid
// i_tx_tready          in   1       merged output ready
// o_tx_tdata/tkeep/tuser/tlast  out  DATA_W/KEEP_W/USER_W/1  merged beat
// o_afu_pkt_cnt        out  CNT_W   AFU packets forwarded, wraps
// o_mmio_pkt_cnt       out  CNT_W   MMIO packets forwarded, wraps
// o_busy               out  1       state != IDLE or skid non-empty
// BEHAVIOUR
// - Reset: state=IDLE, skid empty, starve_cnt=0, counters=0.
// - Reset outputs: o_tx_tvalid=0, o_afu_tready=0, o_mmio_tready=0, o_busy=0; o_tx_* data don't-care.
// - FSM states: IDLE, AFU_PKT, MMIO_PKT.
// - IDLE decision, combinational, same cycle as the SOP beat (no bubble):
//   - grant MMIO if i_mmio_tvalid & (~i_afu_tvalid | i_sel_mmio_rsp | starve_cnt==STARVE_LIMIT).
//   - else grant AFU if i_afu_tvalid.
//   - else no grant.
// - Ready qualification:
//   - o_afu_tready  = skid_ready & (state==AFU_PKT  | IDLE & afu_grant).
//   - o_mmio_tready = skid_ready & (state==MMIO_PKT | IDLE & mmio_grant).
//   - Never both high in the same cycle.
// - Transitions:
//   - IDLE -> X_PKT when the granted SOP beat is accepted with tlast=0.
//   - Stay in IDLE if that beat has tlast=1 (single-beat packet).
//   - X_PKT -> IDLE when a beat with tlast=1 is accepted on X.
//   - While locked, the other source is held off even if valid.
// - starve_cnt:
//   - +1 (saturating at STARVE_LIMIT) on each accepted AFU SOP while i_mmio_tvalid=1.
//   - Cleared on accepted MMIO SOP.
// - Counters: +1 on each accepted tlast beat of the respective source; wrap modulo 2^CNT_W.
// - Skid buffer:
//   - skid_ready = ~(2 entries full).
//   - Accepted beat appears on o_tx_* 1 cycle later (latency 1).
//   - Full throughput of 1 beat/clk when i_tx_tready=1.
//   - o_tx_* held stable while o_tx_tvalid & ~i_tx_tready.
// - Simultaneous push and pop with 1 entry buffered: occupancy unchanged, ordering preserved.
// - Reset mid-packet: all state discarded.
//   - Upstream sources are also reset by the same rst_n, so no partial-packet tail resumes.
//   - The next accepted beat is treated as SOP.
// - i_sel_mmio_rsp is advisory only; it is sampled only in IDLE.
// TESTING
// - MMIO only: 1-beat response with AFU idle, i_tx_tready=1.
//   -> o_mmio_tready=1 same cycle, o_tx_tvalid=1 next cycle, o_mmio_pkt_cnt=1.
// - Interleave guard: AFU 4-beat packet in progress, MMIO asserted at beat 2.
//   -> o_mmio_tready=0 until AFU tlast accepted; MMIO beat exits immediately after AFU beat 4.
// - Starvation: STARVE_LIMIT=4, AFU back-to-back 2-beat packets, i_sel_mmio_rsp=0, MMIO valid.
//   -> exactly 4 AFU packets, then MMIO packet; starve_cnt returns to 0.
// - Backpressure: i_tx_tready=0 for 5 cycles during AFU 3-beat packet.
//   -> at most 2 beats accepted, o_afu_tready=0, o_tx_tdata stable, no loss/duplication.
// - Reset mid-packet: rst_n low 1 cycle after beat 2 of a 4-beat MMIO packet.
//   -> o_tx_tvalid=0 and counters=0 next cycle; a new AFU SOP is accepted from IDLE.
// - Counter wrap: CNT_W=4, 17 one-beat AFU packets -> o_afu_pkt_cnt=1.

Source files
------------

// File: rtl/port_tx_rsp_arb.sv
// ---------------------------------------------------------------------------
// port_tx_rsp_arb
//
// Packet-atomic 2:1 arbiter that sits directly after the AFU TX
// store-and-forward FIFO. It merges the AFU TX stream and the port MMIO
// read-response stream onto one upstream AXI-S TX link. Beats of different
// packets are never interleaved. A 2-entry skid buffer registers the merged
// stream.
//
// MMIO responses win in IDLE when:
//   - the AFU path is not valid, or
//   - the AFU FIFO reports idle (i_sel_mmio_rsp), or
//   - STARVE_LIMIT AFU packets have started while an MMIO response waited.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   i_afu_t*/o_afu_tready       AFU TX FIFO output stream
//   i_sel_mmio_rsp              AFU FIFO empty and nothing in flight (advisory)
//   i_mmio_t*/o_mmio_tready     MMIO read-response stream
//   o_tx_t*/i_tx_tready         merged upstream stream (1-cycle latency)
//   o_afu_pkt_cnt               AFU packets forwarded, wraps
//   o_mmio_pkt_cnt              MMIO packets forwarded, wraps
//   o_busy                      packet locked or skid buffer non-empty
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | between packets; grant decided combinationally on SOP
// ST_AFU_PKT  | AFU packet in progress; MMIO held off until AFU tlast
// ST_MMIO_PKT | MMIO packet in progress; AFU held off until MMIO tlast
// ---------------------------------------------------------------------------
module port_tx_rsp_arb #(
    parameter int DATA_W       = 512,
    parameter int USER_W       = 10,
    parameter int KEEP_W       = DATA_W / 8,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_afu_tvalid,
    output logic              o_afu_tready,
    input  logic [DATA_W-1:0] i_afu_tdata,
    input  logic [KEEP_W-1:0] i_afu_tkeep,
    input  logic [USER_W-1:0] i_afu_tuser,
    input  logic              i_afu_tlast,

    input  logic              i_sel_mmio_rsp,

    input  logic              i_mmio_tvalid,
    output logic              o_mmio_tready,
    input  logic [DATA_W-1:0] i_mmio_tdata,
    input  logic [KEEP_W-1:0] i_mmio_tkeep,
    input  logic [USER_W-1:0] i_mmio_tuser,
    input  logic              i_mmio_tlast,

    output logic              o_tx_tvalid,
    input  logic              i_tx_tready,
    output logic [DATA_W-1:0] o_tx_tdata,
    output logic [KEEP_W-1:0] o_tx_tkeep,
    output logic [USER_W-1:0] o_tx_tuser,
    output logic              o_tx_tlast,

    output logic [CNT_W-1:0]  o_afu_pkt_cnt,
    output logic [CNT_W-1:0]  o_mmio_pkt_cnt,
    output logic              o_busy
);

    localparam int BEAT_W = DATA_W + KEEP_W + USER_W + 1;
    localparam int SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_AFU_PKT  = 2'd1,
        ST_MMIO_PKT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [CNT_W-1:0]  afu_cnt_q, afu_cnt_d;
    logic [CNT_W-1:0]  mmio_cnt_q, mmio_cnt_d;

    logic [BEAT_W-1:0] skid_mem_q [2];
    logic [BEAT_W-1:0] skid_mem_d [2];
    logic              skid_wr_ptr_q, skid_wr_ptr_d;
    logic              skid_rd_ptr_q, skid_rd_ptr_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;

    logic              in_idle;
    logic              skid_ready;
    logic              mmio_grant;
    logic              afu_grant;
    logic              afu_sel;
    logic              mmio_sel;
    logic              afu_fire;
    logic              mmio_fire;
    logic              push;
    logic              pop;
    logic [BEAT_W-1:0] push_beat;

    // ------------------------------------------------------------------
    // Arbitration and ready qualification
    // ------------------------------------------------------------------
    // skid_ready depends only on registered occupancy, so neither
    // o_*_tready has a combinational path from i_tx_tready.
    assign in_idle    = (state_q == ST_IDLE);
    assign skid_ready = (skid_cnt_q != 2'd2);

    // i_sel_mmio_rsp only matters here, i.e. only while IDLE.
    assign mmio_grant = in_idle & i_mmio_tvalid &
                        (~i_afu_tvalid | i_sel_mmio_rsp | (starve_cnt_q == STARVE_MAX));
    assign afu_grant  = in_idle & ~mmio_grant & i_afu_tvalid;

    // The two selects are mutually exclusive, so at most one ready is high.
    assign afu_sel    = (state_q == ST_AFU_PKT)  | afu_grant;
    assign mmio_sel   = (state_q == ST_MMIO_PKT) | mmio_grant;

    assign o_afu_tready  = skid_ready & afu_sel;
    assign o_mmio_tready = skid_ready & mmio_sel;

    assign afu_fire  = o_afu_tready  & i_afu_tvalid;
    assign mmio_fire = o_mmio_tready & i_mmio_tvalid;

    // ------------------------------------------------------------------
    // FSM, starvation counter, packet statistics
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        afu_cnt_d    = afu_cnt_q;
        mmio_cnt_d   = mmio_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Single-beat packets never leave IDLE.
                if (afu_fire && !i_afu_tlast) begin
                    state_d = ST_AFU_PKT;
                end else if (mmio_fire && !i_mmio_tlast) begin
                    state_d = ST_MMIO_PKT;
                end
            end
            ST_AFU_PKT: begin
                if (afu_fire && i_afu_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MMIO_PKT: begin
                if (mmio_fire && i_mmio_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only SOP beats (accepted in IDLE) move the starvation counter.
        if (in_idle && afu_fire && i_mmio_tvalid && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end
        if (in_idle && mmio_fire) begin
            starve_cnt_d = '0;
        end

        if (afu_fire && i_afu_tlast) begin
            afu_cnt_d = afu_cnt_q + CNT_W'(1);
        end
        if (mmio_fire && i_mmio_tlast) begin
            mmio_cnt_d = mmio_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // 2-entry skid buffer (circular, head drives o_tx_*)
    // ------------------------------------------------------------------
    assign push      = afu_fire | mmio_fire;
    assign pop       = (skid_cnt_q != 2'd0) & i_tx_tready;
    assign push_beat = afu_sel ? {i_afu_tdata,  i_afu_tkeep,  i_afu_tuser,  i_afu_tlast}
                               : {i_mmio_tdata, i_mmio_tkeep, i_mmio_tuser, i_mmio_tlast};

    always_comb begin
        skid_mem_d    = skid_mem_q;
        skid_wr_ptr_d = skid_wr_ptr_q;
        skid_rd_ptr_d = skid_rd_ptr_q;
        skid_cnt_d    = skid_cnt_q;

        if (push) begin
            skid_mem_d[skid_wr_ptr_q] = push_beat;
            skid_wr_ptr_d             = ~skid_wr_ptr_q;
        end
        if (pop) begin
            skid_rd_ptr_d = ~skid_rd_ptr_q;
        end

        // Push never happens when full, pop never when empty.
        case ({push, pop})
            2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
            2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
            default: skid_cnt_d = skid_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            starve_cnt_q  <= '0;
            afu_cnt_q     <= '0;
            mmio_cnt_q    <= '0;
            skid_wr_ptr_q <= 1'b0;
            skid_rd_ptr_q <= 1'b0;
            skid_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            afu_cnt_q     <= afu_cnt_d;
            mmio_cnt_q    <= mmio_cnt_d;
            skid_wr_ptr_q <= skid_wr_ptr_d;
            skid_rd_ptr_q <= skid_rd_ptr_d;
            skid_cnt_q    <= skid_cnt_d;
        end
    end

    // Payload storage needs no reset; it is qualified by skid_cnt_q.
    always_ff @(posedge clk) begin
        skid_mem_q <= skid_mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_tx_tvalid = (skid_cnt_q != 2'd0);
    assign {o_tx_tdata, o_tx_tkeep, o_tx_tuser, o_tx_tlast} = skid_mem_q[skid_rd_ptr_q];

    assign o_afu_pkt_cnt  = afu_cnt_q;
    assign o_mmio_pkt_cnt = mmio_cnt_q;
    assign o_busy         = ~in_idle | (skid_cnt_q != 2'd0);

endmodule
